// File: rtl/registerfile_if.sv
// Writeback, status-flag and read-port bundle between the pipeline and the register file.
// The pipeline side is the master; the register file is the slave.
interface registerfile_if;
  logic        write;
  logic [3:0]  write_index;
  logic [31:0] write_data;
  logic        write_immediate;
  logic [15:0] write_immediate_data;
  logic [1:0]  write_immediate_type;
  logic        status_register_write;
  logic        alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out;
  logic [3:0]  read_reg_a_index, read_reg_b_index, read_reg_c_index;
  logic [31:0] read_reg_a_data, read_reg_b_data, read_reg_c_data;
  logic        alu_carry, alu_zero, alu_neg, alu_over;
  logic        write_conflict;

  modport master (
    output write, write_index, write_data,
    output write_immediate, write_immediate_data, write_immediate_type,
    output status_register_write, alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out,
    output read_reg_a_index, read_reg_b_index, read_reg_c_index,
    input  read_reg_a_data, read_reg_b_data, read_reg_c_data,
    input  alu_carry, alu_zero, alu_neg, alu_over, write_conflict
  );

  modport slave (
    input  write, write_index, write_data,
    input  write_immediate, write_immediate_data, write_immediate_type,
    input  status_register_write, alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out,
    input  read_reg_a_index, read_reg_b_index, read_reg_c_index,
    output read_reg_a_data, read_reg_b_data, read_reg_c_data,
    output alu_carry, alu_zero, alu_neg, alu_over, write_conflict
  );
endinterface

// File: rtl/registerfile.sv
// MaxiCore32 register file: 16x32 registers, one write per cycle (full or 16-bit immediate),
// three combinational read ports with write-through bypass, plus the latched ALU flags.
module registerfile (
  input  logic            clock,
  input  logic            reset,
  registerfile_if.slave   bus
);
  localparam int NUM_REGS  = 16;
  localparam int NUM_PORTS = 3;
  localparam int REG_W     = 32;

  typedef enum logic [1:0] {
    IT_UNSIGNED = 2'd0,
    IT_SIGNED   = 2'd1,
    IT_TOP      = 2'd2,
    IT_BOTTOM   = 2'd3
  } imm_type_e;

  typedef struct packed {
    logic             en;
    logic [3:0]       index;
    logic [REG_W-1:0] value;
  } wr_req_t;

  logic [NUM_REGS-1:0][REG_W-1:0]  regs;
  logic [3:0]                      flags;
  logic                            conflict_q;
  wr_req_t                         wr;
  logic [REG_W-1:0]                old_val;
  logic [NUM_PORTS-1:0][3:0]       rd_index;
  logic [NUM_PORTS-1:0][REG_W-1:0] rd_data;

  // Full write takes priority over an immediate; immediates merge with the stored word.
  always_comb begin
    wr       = '0;
    old_val  = regs[bus.write_index];
    wr.en    = bus.write | bus.write_immediate;
    wr.index = bus.write_index;
    if (bus.write) begin
      wr.value = bus.write_data;
    end else begin
      unique case (imm_type_e'(bus.write_immediate_type))
        IT_UNSIGNED: wr.value = {16'h0000, bus.write_immediate_data};
        IT_SIGNED:   wr.value = {{16{bus.write_immediate_data[15]}}, bus.write_immediate_data};
        IT_TOP:      wr.value = {bus.write_immediate_data, old_val[15:0]};
        IT_BOTTOM:   wr.value = {old_val[31:16], bus.write_immediate_data};
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      regs       <= '0;
      flags      <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (wr.en) regs[wr.index] <= wr.value;
      if (bus.status_register_write)
        flags <= {bus.alu_carry_out, bus.alu_zero_out, bus.alu_neg_out, bus.alu_over_out};
      conflict_q <= bus.write & bus.write_immediate;
    end
  end

  assign rd_index = {bus.read_reg_c_index, bus.read_reg_b_index, bus.read_reg_a_index};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    always_comb begin
      rd_data[p] = regs[rd_index[p]];
      if (wr.en && rd_index[p] == wr.index) rd_data[p] = wr.value;
    end
  end

  assign bus.read_reg_a_data = rd_data[0];
  assign bus.read_reg_b_data = rd_data[1];
  assign bus.read_reg_c_data = rd_data[2];

  // Flags are deliberately not bypassed: consumers see the latched state only.
  assign {bus.alu_carry, bus.alu_zero, bus.alu_neg, bus.alu_over} = flags;
  assign bus.write_conflict = conflict_q;
endmodule

// File: tb/tb_registerfile.sv
// Directed bench for registerfile: reset, immediates, bypass, conflict flag, status flags, sweep.
module tb_registerfile;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  registerfile_if rf_if ();

  registerfile dut (
    .clock (clock),
    .reset (reset),
    .bus   (rf_if.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rf_if.write                 = 1'b0;
    rf_if.write_index           = 4'd0;
    rf_if.write_data            = 32'h0;
    rf_if.write_immediate       = 1'b0;
    rf_if.write_immediate_data  = 16'h0;
    rf_if.write_immediate_type  = 2'd0;
    rf_if.status_register_write = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic sel(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    rf_if.read_reg_a_index = a;
    rf_if.read_reg_b_index = b;
    rf_if.read_reg_c_index = c;
    #1;
  endtask

  task automatic wr_full(input logic [3:0] idx, input logic [31:0] d);
    idle();
    rf_if.write       = 1'b1;
    rf_if.write_index = idx;
    rf_if.write_data  = d;
  endtask

  task automatic wr_imm(input logic [3:0] idx, input logic [1:0] t, input logic [15:0] d);
    idle();
    rf_if.write_immediate      = 1'b1;
    rf_if.write_index          = idx;
    rf_if.write_immediate_type = t;
    rf_if.write_immediate_data = d;
  endtask

  function automatic logic [31:0] flags4();
    return {28'h0, rf_if.alu_carry, rf_if.alu_zero, rf_if.alu_neg, rf_if.alu_over};
  endfunction

  initial begin
    idle();
    {rf_if.alu_carry_out, rf_if.alu_zero_out, rf_if.alu_neg_out, rf_if.alu_over_out} = 4'b0000;
    sel(4'd0, 4'd0, 4'd0);

    // Reset held two cycles with a write presented: the write must not survive.
    @(negedge clock);
    reset = 1'b0;
    wr_full(4'd5, 32'hDEADBEEF);
    tick();
    tick();
    reset = 1'b1;
    idle();
    sel(4'd5, 4'd0, 4'd15);
    check("reset_r5_a", rf_if.read_reg_a_data, 32'h0);
    check("reset_r0_b", rf_if.read_reg_b_data, 32'h0);
    check("reset_r15_c", rf_if.read_reg_c_data, 32'h0);
    check("reset_flags", flags4(), 32'h0);
    check("reset_conflict", {31'h0, rf_if.write_conflict}, 32'h0);

    // Immediate forms on r3, each visible through the bypass before the edge.
    sel(4'd3, 4'd3, 4'd3);
    wr_imm(4'd3, 2'd0, 16'h8001); #1;
    check("imm_unsigned", rf_if.read_reg_a_data, 32'h00008001);
    tick();
    wr_imm(4'd3, 2'd1, 16'h8001); #1;
    check("imm_signed", rf_if.read_reg_b_data, 32'hFFFF8001);
    tick();
    wr_imm(4'd3, 2'd2, 16'h1234); #1;
    check("imm_top", rf_if.read_reg_c_data, 32'h12348001);
    tick();
    wr_imm(4'd3, 2'd3, 16'hABCD); #1;
    check("imm_bottom", rf_if.read_reg_a_data, 32'h1234ABCD);
    tick();
    idle(); #1;
    check("imm_stored", rf_if.read_reg_b_data, 32'h1234ABCD);

    // Same-cycle bypass on all three ports.
    sel(4'd7, 4'd7, 4'd7);
    wr_full(4'd7, 32'h55AA55AA); #1;
    check("byp_a", rf_if.read_reg_a_data, 32'h55AA55AA);
    check("byp_b", rf_if.read_reg_b_data, 32'h55AA55AA);
    check("byp_c", rf_if.read_reg_c_data, 32'h55AA55AA);
    tick();
    wr_full(4'd7, 32'h11112222);
    tick();
    idle(); #1;
    check("r7_stored", rf_if.read_reg_a_data, 32'h11112222);
    sel(4'd7, 4'd3, 4'd7);
    wr_imm(4'd7, 2'd2, 16'h9999); #1;
    check("byp_top_merge", rf_if.read_reg_a_data, 32'h99992222);
    check("byp_other_port", rf_if.read_reg_b_data, 32'h1234ABCD);
    tick();
    idle(); #1;
    check("top_merge_stored", rf_if.read_reg_c_data, 32'h99992222);

    // Simultaneous strobes: full write wins and the conflict flag pulses once.
    sel(4'd2, 4'd2, 4'd2);
    wr_full(4'd2, 32'h00000042);
    rf_if.write_immediate      = 1'b1;
    rf_if.write_immediate_type = 2'd0;
    rf_if.write_immediate_data = 16'h7777;
    #1;
    check("conflict_bypass", rf_if.read_reg_a_data, 32'h00000042);
    check("conflict_pre", {31'h0, rf_if.write_conflict}, 32'h0);
    tick();
    idle(); #1;
    check("conflict_r2", rf_if.read_reg_b_data, 32'h00000042);
    check("conflict_set", {31'h0, rf_if.write_conflict}, 32'h1);
    tick();
    check("conflict_clear", {31'h0, rf_if.write_conflict}, 32'h0);

    // Flags latch alongside a register write; not bypassed; hold when not strobed.
    sel(4'd1, 4'd1, 4'd1);
    wr_full(4'd1, 32'h00000010);
    rf_if.status_register_write = 1'b1;
    {rf_if.alu_carry_out, rf_if.alu_zero_out, rf_if.alu_neg_out, rf_if.alu_over_out} = 4'b1010;
    #1;
    check("flags_no_bypass", flags4(), 32'h0);
    tick();
    idle();
    {rf_if.alu_carry_out, rf_if.alu_zero_out, rf_if.alu_neg_out, rf_if.alu_over_out} = 4'b0101;
    #1;
    check("flags_latched", flags4(), 32'hA);
    check("flags_r1", rf_if.read_reg_a_data, 32'h00000010);
    tick();
    check("flags_hold", flags4(), 32'hA);

    // Sweep every register, then read back with differing indices per port.
    for (int i = 0; i < 16; i++) begin
      wr_full(4'(i), 32'h01010101 * (i + 1));
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      sel(4'(i), 4'((i + 5) % 16), 4'((i + 11) % 16));
      check($sformatf("sweep_a_r%0d", i), rf_if.read_reg_a_data, 32'h01010101 * (i + 1));
      check($sformatf("sweep_b_r%0d", (i + 5) % 16), rf_if.read_reg_b_data,
            32'h01010101 * ((i + 5) % 16 + 1));
      check($sformatf("sweep_c_r%0d", (i + 11) % 16), rf_if.read_reg_c_data,
            32'h01010101 * ((i + 11) % 16 + 1));
    end
    check("sweep_r0_kept", (rf_if.read_reg_a_index == 4'd15) ? 32'h01010101 : 32'h0,
          32'h01010101);
    sel(4'd0, 4'd0, 4'd0);
    check("sweep_r0", rf_if.read_reg_a_data, 32'h01010101);

    // Reset overrides concurrent write and status strobes; bypass still shows during reset.
    sel(4'd9, 4'd9, 4'd9);
    reset = 1'b0;
    wr_full(4'd9, 32'hCAFEF00D);
    rf_if.status_register_write = 1'b1;
    {rf_if.alu_carry_out, rf_if.alu_zero_out, rf_if.alu_neg_out, rf_if.alu_over_out} = 4'b1111;
    #1;
    check("rst_bypass", rf_if.read_reg_a_data, 32'hCAFEF00D);
    tick();
    reset = 1'b1;
    idle(); #1;
    check("rst_r9", rf_if.read_reg_b_data, 32'h0);
    check("rst_flags", flags4(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/registerfile.md
# registerfile

Architectural register file and status register for the MaxiCore32 pipeline. Accepts the writeback port driven by the stage-2 pipeline register (memory/ALU/return-address writes and 16-bit immediate loads) and supplies the register read ports used by stage 1 and the ALU. Also holds the four ALU condition flags consumed by stage-2 branch/jump condition evaluation. Sixteen 32-bit registers, one write per cycle, three combinational read ports with same-cycle write bypass.

## Interface
- No parameters: 16 registers × 32 bits, fixed.
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- write  in  1  full-word write strobe
- write_index  in  4  destination register for write or write_immediate
- write_data  in  32  data for full-word write
- write_immediate  in  1  immediate write strobe
- write_immediate_data  in  16  immediate payload
- write_immediate_type  in  2  IT_UNSIGNED=0, IT_SIGNED=1, IT_TOP=2, IT_BOTTOM=3
- status_register_write  in  1  latch ALU flags this cycle
- alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out  in  1 each  flags from ALU
- read_reg_a_index, read_reg_b_index, read_reg_c_index  in  4 each  read port selects
- read_reg_a_data, read_reg_b_data, read_reg_c_data  out  32 each  read port data
- alu_carry, alu_zero, alu_neg, alu_over  out  1 each  latched status flags
- write_conflict  out  1  registered: previous cycle had write and write_immediate together

## Operation
- Registers r0–r15 all general purpose; r0 is writable (not hardwired zero).
- Full write: write=1 → reg[write_index] ← write_data.
- Immediate write (write_immediate=1, write=0), d = write_immediate_data, old = reg[write_index]:
  - IT_UNSIGNED: {16'h0, d}
  - IT_SIGNED: {{16{d[15]}}, d}
  - IT_TOP: {d, old[15:0]}
  - IT_BOTTOM: {old[31:16], d}
- write and write_immediate both 1: full write wins, immediate ignored, write_conflict=1 on the next cycle (cleared the cycle after unless repeated). Stage 2 never does this legally; flag is a verification aid.
- Neither strobe: no register change; write_index/write_data/immediate inputs ignored.
- status_register_write=1 → {alu_carry, alu_zero, alu_neg, alu_over} ← {alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out}. Independent of register writes; both may occur same cycle.
- Read ports: combinational. If a strobe is active this cycle and read index == write_index, port returns the value being written (for IT_TOP/IT_BOTTOM, the merged value) — write-through bypass. Otherwise returns stored value. All three ports bypass independently; multiple ports may select the same register.
- Flag outputs are not bypassed: reflect latched value only.

## Timing
- Reset (reset=0 at rising edge): all 16 registers 0x00000000, all four flags 0, write_conflict 0. Reset overrides any concurrent write/status strobe. Read ports during reset cycle still show combinational bypass of presented strobes; stored values clear at the edge.
- Write latency: value stored at the edge where strobe is sampled; visible on read ports combinationally the same cycle (bypass) and from stored state thereafter.
- Back-to-back writes to same register on consecutive cycles: each applied in order; IT_TOP/IT_BOTTOM merge with the value stored by the preceding cycle.
- Flag latency: flags updated at the sampling edge, visible at outputs the following cycle.
- No handshake; every strobe accepted every cycle, no stall.

## Test plan
- Reset: hold reset=0 two cycles with write=1, index 5, data 0xDEADBEEF → after release all ports read 0, flags 0, write_conflict 0.
- Immediates on r3: IT_UNSIGNED 0x8001 → 0x00008001; IT_SIGNED 0x8001 → 0xFFFF8001; IT_TOP 0x1234 → 0x12348001; IT_BOTTOM 0xABCD next cycle → 0x1234ABCD.
- Bypass: write r7=0x55AA55AA, all ports index 7 same cycle → all read 0x55AA55AA before edge; with r7 = 0x11112222, IT_TOP 0x9999 presented → port shows 0x99992222 combinationally.
- Conflict: write=1 data 0x00000042 and write_immediate=1 IT_UNSIGNED 0x7777 to r2 → r2=0x00000042, write_conflict=1 next cycle, 0 the cycle after.
- Flags: status_register_write=1 with carry=1,zero=0,neg=1,over=0 plus write r1=0x10 same cycle → both applied; flags 1,0,1,0 next cycle; status_register_write=0 with changed inputs → flags unchanged.
- Sweep: write r0–r15 with 0x01010101×(i+1) on consecutive cycles, read back on all three ports with differing indices → all values correct, r0 retains written value.
